// File: rtl/tdm_pkg.sv
// rtl/tdm_pkg.sv - shared types and widths for the TDM demultiplexer
package tdm_pkg;

  localparam int N_CH_DEF = 4;
  localparam int W_DEF    = 8;

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    COLLECT = 2'd1,
    CHECK   = 2'd2
  } state_e;

  // Counter needs at least one bit even for a two-channel frame.
  function automatic int cnt_w(input int n);
    return (n <= 2) ? 1 : $clog2(n);
  endfunction

endpackage

// File: rtl/tdm_wr_decode.sv
// rtl/tdm_wr_decode.sv - channel counter to one-hot staging write enable
module tdm_wr_decode #(
  parameter int N_CH  = 4,
  parameter int CNT_W = 2
) (
  input  logic [CNT_W-1:0] cnt,
  input  logic             en,
  output logic [N_CH-1:0]  wen
);

  always_comb begin
    wen = '0;
    for (int k = 0; k < N_CH; k++) begin
      wen[k] = en && (cnt == CNT_W'(k));
    end
  end

endmodule

// File: rtl/tdm_demux.sv
// rtl/tdm_demux.sv - framed word-serial to parallel demux; TDM_DEMUX_PARITY_EN adds a trailing parity beat
module tdm_demux
  import tdm_pkg::*;
#(
  parameter int N_CH = N_CH_DEF,
  parameter int W    = W_DEF
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              in_valid,
  input  logic              in_sof,
  input  logic [W-1:0]      in_data,
  output logic              out_valid,
  output logic [N_CH*W-1:0] out_data,
  output logic              out_err,
  output logic              busy
);

  localparam int              CNT_W = cnt_w(N_CH);
  localparam logic [CNT_W-1:0] LAST = CNT_W'(N_CH - 1);

  state_e              state;
  logic [CNT_W-1:0]    cnt;
  logic [N_CH*W-1:0]   stage;
  logic [N_CH*W-1:0]   next_stage;
  logic [N_CH-1:0]     wen;
  logic [CNT_W-1:0]    sel;
  logic                wr_en;

  // A sof beat always lands in channel 0, whatever state it arrives in.
  assign wr_en = in_valid && (in_sof || (state == COLLECT));
  assign sel   = in_sof ? '0 : cnt;

  tdm_wr_decode #(
    .N_CH  (N_CH),
    .CNT_W (CNT_W)
  ) u_wr_decode (
    .cnt (sel),
    .en  (wr_en),
    .wen (wen)
  );

  always_comb begin
    next_stage = stage;
    for (int k = 0; k < N_CH; k++) begin
      if (wen[k]) next_stage[k*W +: W] = in_data;
    end
  end

`ifdef TDM_DEMUX_PARITY_EN
  logic [W-1:0] parity;

  always_comb begin
    parity = '0;
    for (int k = 0; k < N_CH; k++) begin
      parity = parity ^ stage[k*W +: W];
    end
  end
`endif

  always_ff @(posedge clk) begin
    if (rst) begin
      state     <= IDLE;
      cnt       <= '0;
      stage     <= '0;
      out_data  <= '0;
      out_valid <= 1'b0;
      out_err   <= 1'b0;
      busy      <= 1'b0;
    end else begin
      out_valid <= 1'b0;
      out_err   <= 1'b0;
      stage     <= next_stage;
      if (in_valid) begin
        case (state)
          IDLE: begin
            if (in_sof) begin
              cnt   <= CNT_W'(1);
              state <= COLLECT;
              busy  <= 1'b1;
            end else begin
              out_err <= 1'b1;
            end
          end
          COLLECT: begin
            if (in_sof) begin
              out_err <= 1'b1;
              cnt     <= CNT_W'(1);
            end else if (cnt == LAST) begin
              cnt <= '0;
`ifdef TDM_DEMUX_PARITY_EN
              state <= CHECK;
`else
              state     <= IDLE;
              busy      <= 1'b0;
              out_valid <= 1'b1;
              out_data  <= next_stage;
`endif
            end else begin
              cnt <= cnt + 1'b1;
            end
          end
          CHECK: begin
`ifdef TDM_DEMUX_PARITY_EN
            if (in_sof) begin
              out_err <= 1'b1;
              cnt     <= CNT_W'(1);
              state   <= COLLECT;
            end else begin
              state <= IDLE;
              busy  <= 1'b0;
              if (in_data == parity) begin
                out_valid <= 1'b1;
                out_data  <= stage;
              end else begin
                out_err <= 1'b1;
              end
            end
`else
            state <= IDLE;
            busy  <= 1'b0;
`endif
          end
          default: begin
            state <= IDLE;
            busy  <= 1'b0;
          end
        endcase
      end
    end
  end

endmodule

// File: tb/tb_tdm_demux.sv
// tb/tb_tdm_demux.sv - scoreboard bench for tdm_demux (N_CH=4, W=8)
module tb_tdm_demux;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        in_valid = 1'b0;
  logic        in_sof = 1'b0;
  logic [7:0]  in_data = '0;
  logic        out_valid;
  logic [31:0] out_data;
  logic        out_err;
  logic        busy;

  typedef struct {
    bit          err;
    logic [31:0] data;
    int          cyc;
  } exp_t;

  exp_t        q[$];
  int          cyc = 0;
  int          n_tests = 0;
  int          n_fail = 0;
  logic [31:0] exp_out = '0;

  tdm_demux #(.N_CH(4), .W(8)) dut (
    .clk       (clk),
    .rst       (rst),
    .in_valid  (in_valid),
    .in_sof    (in_sof),
    .in_data   (in_data),
    .out_valid (out_valid),
    .out_data  (out_data),
    .out_err   (out_err),
    .busy      (busy)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
    n_tests++;
    if (act !== req) begin
      n_fail++;
      $display("FAIL %s: got %h, expected %h (cycle %0d)", name, act, req, cyc);
    end
  endtask

  // Expectation pushed at drive time: the pulse shows one cycle after acceptance.
  task automatic push(input bit err, input logic [31:0] d);
    exp_t e;
    e.err = err; e.data = d; e.cyc = cyc + 1;
    q.push_back(e);
    if (!err) exp_out = d;
  endtask

  task automatic beat(input bit sof, input logic [7:0] d);
    @(posedge clk); #1;
    in_valid = 1'b1; in_sof = sof; in_data = d;
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) begin
      @(posedge clk); #1;
      in_valid = 1'b0; in_sof = $urandom_range(0, 1); in_data = 8'($urandom);
    end
  endtask

  task automatic gap_busy(input int n);
    for (int i = 0; i < n; i++) begin
      idle(1);
      check("busy_in_gap", 32'(busy), 32'd1);
    end
  endtask

  task automatic send_frame(input logic [31:0] f, input int gap, input bit err_first);
    for (int i = 0; i < 4; i++) begin
      beat(i == 0, f[i*8 +: 8]);
      if (i == 0 && err_first) push(1'b1, exp_out);
`ifndef TDM_DEMUX_PARITY_EN
      if (i == 3) push(1'b0, f);
`endif
      if (i < 3 && gap > 0) gap_busy(gap);
    end
`ifdef TDM_DEMUX_PARITY_EN
    if (gap > 0) gap_busy(gap);
    beat(1'b0, f[7:0] ^ f[15:8] ^ f[23:16] ^ f[31:24]);
    push(1'b0, f);
`endif
  endtask

  // Monitor: pops the scoreboard on every output pulse and flags missed ones.
  always @(negedge clk) begin
    while (q.size() > 0 && q[0].cyc < cyc) begin
      n_tests++; n_fail++;
      $display("FAIL missing_pulse: no pulse, expected err=%0d data=%h at cycle %0d", q[0].err, q[0].data, q[0].cyc);
      void'(q.pop_front());
    end
    if (out_valid && out_err) begin
      n_tests++; n_fail++;
      $display("FAIL both_pulses: out_valid=1 out_err=1, expected at most one (cycle %0d)", cyc);
    end else if (out_valid || out_err) begin
      if (q.size() == 0) begin
        n_tests++; n_fail++;
        $display("FAIL unexpected_pulse: valid=%0d err=%0d data=%h, expected none (cycle %0d)", out_valid, out_err, out_data, cyc);
      end else begin
        exp_t e;
        e = q.pop_front();
        check("pulse_kind_err", 32'(out_err), 32'(e.err));
        check("pulse_data", out_data, e.data);
        check("pulse_cycle", cyc, e.cyc);
      end
    end
  end

  initial begin
    repeat (2) @(posedge clk);
    #1;
    check("reset_out_data", out_data, 32'h0);
    check("reset_busy", 32'(busy), 32'd0);
    check("reset_out_valid", 32'(out_valid), 32'd0);
    check("reset_out_err", 32'(out_err), 32'd0);
    rst = 1'b0;
    idle(2);

    send_frame(32'h44332211, 0, 1'b0);
    idle(3);
    check("idle_after_frame_busy", 32'(busy), 32'd0);

    send_frame(32'h44332211, 2, 1'b0);
    idle(3);

    beat(1'b0, 8'h55);
    push(1'b1, exp_out);
    idle(3);
    check("orphan_keeps_out_data", out_data, 32'h44332211);

    beat(1'b1, 8'hA1);
    beat(1'b0, 8'hA2);
    send_frame(32'hB4B3B2B1, 0, 1'b1);

    send_frame(32'hC4C3C2C1, 0, 1'b0);
    send_frame(32'hD4D3D2D1, 0, 1'b0);
    idle(3);

    beat(1'b1, 8'h01);
    beat(1'b0, 8'h02);
    @(posedge clk); #1;
    rst = 1'b1; in_valid = 1'b0;
    @(posedge clk); #1;
    rst = 1'b0;
    exp_out = '0;
    check("midreset_out_data", out_data, 32'h0);
    check("midreset_busy", 32'(busy), 32'd0);
    idle(2);
    send_frame(32'h0D0C0B0A, 0, 1'b0);
    idle(3);

`ifdef TDM_DEMUX_PARITY_EN
    beat(1'b1, 8'h01); beat(1'b0, 8'h02); beat(1'b0, 8'h04); beat(1'b0, 8'h08);
    beat(1'b0, 8'h0F);
    push(1'b0, 32'h08040201);
    idle(2);
    beat(1'b1, 8'h01); beat(1'b0, 8'h02); beat(1'b0, 8'h04); beat(1'b0, 8'h08);
    beat(1'b0, 8'h0E);
    push(1'b1, 32'h08040201);
    idle(3);
    check("parity_err_keeps_out_data", out_data, 32'h08040201);
`endif

    idle(4);
    check("scoreboard_drained", 32'(q.size()), 32'd0);
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
